// File: rtl/decoder_4x7.sv
// rtl/decoder_4x7.sv - registered 4-bit hex to 7-segment decoder with blanking enable
//
// Purpose:
//    Converts a 4-bit digit value (0x0-0xF) into 7-segment drive levels.
//    The decode is computed combinationally and captured in a segment
//    register, so decoder_out is one clk cycle behind the inputs and has
//    no combinational path from binary_in or enable.
//
// Parameters:
//    ACTIVE_LOW  1 = lit segment driven 0 (common anode)
//                0 = lit segment driven 1 (common cathode)
//
// Ports:
//    clk          in   1  system clock, rising edge
//    rst_n        in   1  asynchronous active-low reset, forces blank
//    binary_in    in   4  digit value to display
//    enable       in   1  1 = show digit, 0 = blank digit
//    decoder_out  out  7  segment drive {g,f,e,d,c,b,a}

module decoder_4x7 #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] binary_in,
   input  logic       enable,
   output logic [6:0] decoder_out
);

   // "All segments off" in the polarity of the attached display.
   localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [6:0] seg_hi;   // active-high segment pattern for binary_in
   logic [6:0] seg_d;
   logic [6:0] seg_q;

   always_comb begin
      seg_hi = 7'h00;
      unique case (binary_in)
         4'h0: seg_hi = 7'h3F;
         4'h1: seg_hi = 7'h06;
         4'h2: seg_hi = 7'h5B;
         4'h3: seg_hi = 7'h4F;
         4'h4: seg_hi = 7'h66;
         4'h5: seg_hi = 7'h6D;
         4'h6: seg_hi = 7'h7D;
         4'h7: seg_hi = 7'h07;
         4'h8: seg_hi = 7'h7F;
         4'h9: seg_hi = 7'h6F;
         4'hA: seg_hi = 7'h77;
         4'hB: seg_hi = 7'h7C;
         4'hC: seg_hi = 7'h39;
         4'hD: seg_hi = 7'h5E;
         4'hE: seg_hi = 7'h79;
         4'hF: seg_hi = 7'h71;
         default: seg_hi = 7'h00;
      endcase
   end

   // Polarity is applied before the register so the output pins come
   // straight from flops and never pass through an intermediate state.
   always_comb begin
      seg_d = BLANK;
      if (enable) begin
         seg_d = seg_hi ^ {7{ACTIVE_LOW}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= BLANK;
      end else begin
         seg_q <= seg_d;
      end
   end

   assign decoder_out = seg_q;

endmodule

// File: tb/tb_decoder_4x7.sv
// tb/tb_decoder_4x7.sv - self-checking bench for decoder_4x7

module tb_decoder_4x7;

   logic       clk;
   logic       rst_n;

   logic [3:0] b_ah;
   logic       en_ah;
   logic [6:0] out_ah;

   logic [3:0] b_al;
   logic       en_al;
   logic [6:0] out_al;

   logic [3:0] b_m0, b_m1, b_m2;
   logic       en_m;
   logic [6:0] out_m0, out_m1, out_m2;

   int n_checks;
   int n_errors;

   logic [6:0] exp_tbl [16];

   decoder_4x7 #(.ACTIVE_LOW(1'b0)) u_ah (
      .clk(clk), .rst_n(rst_n), .binary_in(b_ah), .enable(en_ah), .decoder_out(out_ah));

   decoder_4x7 #(.ACTIVE_LOW(1'b1)) u_al (
      .clk(clk), .rst_n(rst_n), .binary_in(b_al), .enable(en_al), .decoder_out(out_al));

   decoder_4x7 #(.ACTIVE_LOW(1'b0)) u_m0 (
      .clk(clk), .rst_n(rst_n), .binary_in(b_m0), .enable(en_m), .decoder_out(out_m0));

   decoder_4x7 #(.ACTIVE_LOW(1'b0)) u_m1 (
      .clk(clk), .rst_n(rst_n), .binary_in(b_m1), .enable(en_m), .decoder_out(out_m1));

   decoder_4x7 #(.ACTIVE_LOW(1'b0)) u_m2 (
      .clk(clk), .rst_n(rst_n), .binary_in(b_m2), .enable(en_m), .decoder_out(out_m2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs are changed at the falling edge; one rising edge then passes
   // and outputs are sampled at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      exp_tbl[0]  = 7'h3F; exp_tbl[1]  = 7'h06; exp_tbl[2]  = 7'h5B; exp_tbl[3]  = 7'h4F;
      exp_tbl[4]  = 7'h66; exp_tbl[5]  = 7'h6D; exp_tbl[6]  = 7'h7D; exp_tbl[7]  = 7'h07;
      exp_tbl[8]  = 7'h7F; exp_tbl[9]  = 7'h6F; exp_tbl[10] = 7'h77; exp_tbl[11] = 7'h7C;
      exp_tbl[12] = 7'h39; exp_tbl[13] = 7'h5E; exp_tbl[14] = 7'h79; exp_tbl[15] = 7'h71;

      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b1;
      b_ah = 4'h8; en_ah = 1'b1;
      b_al = 4'h8; en_al = 1'b1;
      b_m0 = 4'h0; b_m1 = 4'h0; b_m2 = 4'h0; en_m = 1'b0;

      // Reset before the first clock edge: must act with no clock.
      #2 rst_n = 1'b0;
      #1;
      check("reset_async_ah", out_ah, 7'h00);
      check("reset_async_al", out_al, 7'h7F);
      check("reset_async_m1", out_m1, 7'h00);

      // A rising edge while reset is held must not load the decode.
      @(negedge clk);
      check("reset_hold_ah", out_ah, 7'h00);
      check("reset_hold_al", out_al, 7'h7F);
      rst_n = 1'b1;
      step();
      check("reset_release_ah8", out_ah, 7'h7F);
      check("al_8", out_al, 7'h00);

      // Full table sweep on both polarities.
      for (int i = 0; i < 16; i++) begin
         b_ah = 4'(i);
         b_al = 4'(i);
         step();
         check($sformatf("sweep_ah_%0h", i), out_ah, exp_tbl[i]);
         check($sformatf("sweep_al_%0h", i), out_al, ~exp_tbl[i]);
      end

      // Active-low specific points.
      b_al = 4'h0;
      step();
      check("al_0", out_al, 7'h40);
      en_al = 1'b0;
      step();
      check("al_blank", out_al, 7'h7F);
      en_al = 1'b1;

      // Blanking and re-enable.
      b_ah = 4'h3; en_ah = 1'b0;
      step();
      check("blank_ah", out_ah, 7'h00);
      en_ah = 1'b1;
      step();
      check("unblank_ah3", out_ah, 7'h4F);

      // Latency: an input change between edges must not reach the output.
      b_ah = 4'h1;
      step();
      check("latency_1", out_ah, 7'h06);
      #2 b_ah = 4'h2;
      #1 check("latency_hold", out_ah, 7'h06);
      @(posedge clk);
      #1 check("latency_2", out_ah, 7'h5B);

      // Reset asserted mid-operation overrides the current value at once.
      @(negedge clk);
      b_ah = 4'h8;
      step();
      check("midop_pre", out_ah, 7'h7F);
      #2 rst_n = 1'b0;
      #1 check("midop_reset_ah", out_ah, 7'h00);
      check("midop_reset_al", out_al, 7'h7F);
      @(negedge clk);
      rst_n = 1'b1;

      // Multi-instance: shared enable held low keeps every digit blank.
      b_m0 = 4'h5; b_m1 = 4'h6; b_m2 = 4'h4;
      step();
      check("multi_blank_m0", out_m0, 7'h00);
      check("multi_blank_m1", out_m1, 7'h00);
      check("multi_blank_m2", out_m2, 7'h00);

      // Staggered values 0..6 on each digit; outputs must be independent.
      en_m = 1'b1;
      for (int t = 0; t < 7; t++) begin
         b_m0 = 4'(t);
         b_m1 = 4'((t + 2) % 7);
         b_m2 = 4'((t + 4) % 7);
         step();
         check($sformatf("multi_m0_t%0d", t), out_m0, exp_tbl[t]);
         check($sformatf("multi_m1_t%0d", t), out_m1, exp_tbl[(t + 2) % 7]);
         check($sformatf("multi_m2_t%0d", t), out_m2, exp_tbl[(t + 4) % 7]);
      end

      en_m = 1'b0;
      step();
      check("multi_off_m0", out_m0, 7'h00);
      check("multi_off_m2", out_m2, 7'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/decoder_4x7.md
Name: decoder_4x7

Overview:
- Registered 4-bit binary/hex to 7-segment display decoder with an output enable.
- One instance drives one digit; the microwave display (minutes/seconds digits) uses several instances sharing a common enable.
- Combinational lookup feeds a segment register clocked by the system clock.

Parameters:
- ACTIVE_LOW, 0, 1 = segment on is driven 0 (common-anode display); 0 = segment on is driven 1 (common-cathode).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- binary_in  input  4  digit value to display, 0x0–0xF.
- enable  input  1  1 = display the digit; 0 = blank the digit.
- decoder_out  output  7  segment drive, bit order {g,f,e,d,c,b,a} (bit0 = a, bit6 = g).

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n).
- Reset:
  - While rst_n = 0, decoder_out = all segments off: 7'h00 if ACTIVE_LOW = 0, 7'h7F if ACTIVE_LOW = 1.
  - The reset takes effect immediately, with no clock needed.
  - After release, the first rising clk edge loads the normal decode.
- Latency: decoder_out reflects the binary_in and enable values sampled at the previous rising clk edge (1 cycle). There is no combinational path from the inputs to decoder_out.
- Decode table, active-high form (ACTIVE_LOW = 0):
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
- ACTIVE_LOW = 1: the output is the bitwise inverse of the table value.
- enable = 0: the register loads blank (all segments off), regardless of binary_in.
- enable toggling: takes effect on the next edge, with no glitch states in between.
- Every 4-bit code is mapped; there are no illegal input codes.
- Reset asserted mid-operation overrides any pending update. Reset has priority over the clock edge.
- Output changes only on a clk edge or on rst_n assertion.

Test Plan:
- Reset: rst_n = 0 with binary_in = 8 and enable = 1 → decoder_out = 7'h00 immediately, with no clock edge. Release rst_n, then one edge → 7'h7F.
- Sweep: enable = 1, binary_in = 0..F, one value per cycle → decoder_out follows the table one cycle later, e.g. 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, F→71.
- Blanking: enable = 0 with binary_in = 3 → 7'h00 after the next edge. Set enable = 1 → 7'h4F after the following edge.
- Latency check: change binary_in from 1 to 2 between edges → decoder_out stays 06 until the next rising edge, then becomes 5B.
- Active-low build: ACTIVE_LOW = 1 →
  - reset value 7'h7F;
  - binary_in = 0 gives 7'h40;
  - binary_in = 8 gives 7'h00;
  - enable = 0 gives 7'h7F.
- Multi-instance: three instances share enable and are driven 0..6 at staggered times → each output is independent and correct. An instance whose input has never been driven since reset keeps the reset/blank value until its input is valid.
